// File: rtl/vedic_mul4_seq_if.sv
// rtl/vedic_mul4_seq_if.sv - operand/product handshake bundle for vedic_mul4_seq
interface vedic_mul4_seq_if;
  logic       in_valid;
  logic       in_ready;
  logic [3:0] a;
  logic [3:0] b;
  logic       out_valid;
  logic       out_ready;
  logic [7:0] p;
  logic       busy;

  modport master (
    output in_valid, a, b, out_ready,
    input  in_ready, out_valid, p, busy
  );

  modport slave (
    input  in_valid, a, b, out_ready,
    output in_ready, out_valid, p, busy
  );
endinterface

// File: rtl/vedic_mul4_seq.sv
// rtl/vedic_mul4_seq.sv - sequential 4x4 unsigned multiplier built on one 2x2 Vedic cell
module vm_2 (
  input  logic [1:0] a,
  input  logic [1:0] b,
  output logic [3:0] p
);
  logic c1;

  // Urdhva-tiryagbhyam: vertical and crosswise products of the bit pairs
  assign c1   = (a[1] & b[0]) & (a[0] & b[1]);
  assign p[0] = a[0] & b[0];
  assign p[1] = (a[1] & b[0]) ^ (a[0] & b[1]);
  assign p[2] = (a[1] & b[1]) ^ c1;
  assign p[3] = (a[1] & b[1]) & c1;
endmodule

module vedic_mul4_seq (
  input  logic             clk,
  input  logic             rst,
  vedic_mul4_seq_if.slave  bus
);
  typedef enum logic [2:0] {IDLE, STEP0, STEP1, STEP2, STEP3, DONE} state_t;

  state_t     state_q, state_d;
  logic [3:0] ra_q, ra_d;
  logic [3:0] rb_q, rb_d;
  logic [7:0] acc_q, acc_d;
  logic [7:0] p_q, p_d;
  logic       out_valid_q, out_valid_d;
  logic [1:0] op_a, op_b;
  logic [3:0] pp;
  logic [7:0] term;

  vm_2 u_vm_2 (.a(op_a), .b(op_b), .p(pp));

  // Operand halves and partial-product weight chosen by the current step
  always_comb begin
    op_a = ra_q[1:0];
    op_b = rb_q[1:0];
    term = {4'b0000, pp};
    case (state_q)
      STEP1: begin
        op_b = rb_q[3:2];
        term = {2'b00, pp, 2'b00};
      end
      STEP2: begin
        op_a = ra_q[3:2];
        term = {2'b00, pp, 2'b00};
      end
      STEP3: begin
        op_a = ra_q[3:2];
        op_b = rb_q[3:2];
        term = {pp, 4'b0000};
      end
      default: ;
    endcase
  end

  always_comb begin
    state_d     = state_q;
    ra_d        = ra_q;
    rb_d        = rb_q;
    acc_d       = acc_q;
    p_d         = p_q;
    out_valid_d = 1'b0;
    case (state_q)
      IDLE: begin
        if (bus.in_valid) begin
          ra_d    = bus.a;
          rb_d    = bus.b;
          acc_d   = 8'h00;
          state_d = STEP0;
        end
      end
      STEP0: begin
        acc_d   = acc_q + term;
        state_d = STEP1;
      end
      STEP1: begin
        acc_d   = acc_q + term;
        state_d = STEP2;
      end
      STEP2: begin
        acc_d   = acc_q + term;
        state_d = STEP3;
      end
      STEP3: begin
        acc_d   = acc_q + term;
        p_d     = acc_q + term;
        state_d = DONE;
      end
      DONE: begin
        // out_valid is registered, so the first DONE cycle only raises it
        out_valid_d = 1'b1;
        if (out_valid_q && bus.out_ready) begin
          out_valid_d = 1'b0;
          state_d     = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= IDLE;
      ra_q        <= 4'h0;
      rb_q        <= 4'h0;
      acc_q       <= 8'h00;
      p_q         <= 8'h00;
      out_valid_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      ra_q        <= ra_d;
      rb_q        <= rb_d;
      acc_q       <= acc_d;
      p_q         <= p_d;
      out_valid_q <= out_valid_d;
    end
  end

  assign bus.in_ready  = (state_q == IDLE);
  assign bus.busy      = (state_q == STEP0) || (state_q == STEP1) ||
                         (state_q == STEP2) || (state_q == STEP3);
  assign bus.out_valid = out_valid_q;
  assign bus.p         = p_q;
endmodule

// File: tb/tb_vedic_mul4_seq.sv
// tb/tb_vedic_mul4_seq.sv - directed self-checking bench for vedic_mul4_seq
module tb_vedic_mul4_seq;
  logic clk = 1'b0;
  logic rst;
  int   checks = 0;
  int   errors = 0;
  int   cyc = 0;

  vedic_mul4_seq_if bus ();

  vedic_mul4_seq dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  initial begin
    #500000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  task automatic check(input string tag, input int got, input int exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic wait_ready(input string tag);
    int n = 0;
    while (!bus.in_ready && n < 50) begin
      tick();
      n++;
    end
    if (!bus.in_ready) check({tag, "_ready_timeout"}, 0, 1);
  endtask

  task automatic start_op(input logic [3:0] ai, input logic [3:0] bi, input string tag);
    wait_ready(tag);
    bus.a        = ai;
    bus.b        = bi;
    bus.in_valid = 1'b1;
    tick();
    bus.in_valid = 1'b0;
  endtask

  // lat counts edges after the accept edge until out_valid is seen
  task automatic wait_done(output int lat, output int busy_n);
    lat    = 0;
    busy_n = 0;
    while (!bus.out_valid && lat < 30) begin
      if (bus.busy) busy_n++;
      tick();
      lat++;
    end
  endtask

  int lat, busy_n, acc_cyc, prev_cyc;
  logic [3:0] ai, bi;

  initial begin
    bus.in_valid  = 1'b0;
    bus.a         = 4'h0;
    bus.b         = 4'h0;
    bus.out_ready = 1'b1;
    rst           = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    check("rst_in_ready", bus.in_ready, 1);
    check("rst_out_valid", bus.out_valid, 0);
    check("rst_busy", bus.busy, 0);
    check("rst_p", bus.p, 0);
    rst = 1'b0;

    // 0 x 0
    start_op(4'd0, 4'd0, "zero");
    wait_done(lat, busy_n);
    check("zero_latency", lat, 5);
    check("zero_p", bus.p, 8'h00);
    check("zero_busy_cycles", busy_n, 4);
    tick();
    check("zero_in_ready_after", bus.in_ready, 1);
    check("zero_out_valid_after", bus.out_valid, 0);

    // 15 x 15, operands disturbed mid-operation
    wait_ready("max");
    bus.a = 4'd15;
    bus.b = 4'd15;
    bus.in_valid = 1'b1;
    tick();
    bus.a = 4'd3;
    bus.b = 4'd3;
    wait_done(lat, busy_n);
    bus.in_valid = 1'b0;
    check("max_latency", lat, 5);
    check("max_p", bus.p, 8'hE1);
    check("max_busy_cycles", busy_n, 4);
    tick();
    check("max_in_ready_after", bus.in_ready, 1);

    // 9 x 6 with consumer stalled
    bus.out_ready = 1'b0;
    start_op(4'd9, 4'd6, "stall");
    wait_done(lat, busy_n);
    check("stall_latency", lat, 5);
    for (int i = 0; i < 10; i++) begin
      tick();
      check("stall_out_valid", bus.out_valid, 1);
      check("stall_p", bus.p, 8'h36);
      check("stall_in_ready", bus.in_ready, 0);
    end
    bus.out_ready = 1'b1;
    tick();
    check("stall_release_in_ready", bus.in_ready, 1);
    check("stall_release_out_valid", bus.out_valid, 0);
    check("idle_p_hold", bus.p, 8'h36);

    // reset during STEP2 aborts, then first edge after reset accepts
    start_op(4'd12, 4'd13, "abort");
    tick();
    tick();
    check("abort_busy_before", bus.busy, 1);
    rst = 1'b1;
    #1;
    check("abort_busy", bus.busy, 0);
    check("abort_in_ready", bus.in_ready, 1);
    check("abort_out_valid", bus.out_valid, 0);
    check("abort_p", bus.p, 0);
    bus.a = 4'd7;
    bus.b = 4'd5;
    bus.in_valid = 1'b1;
    tick();
    check("abort_out_valid_in_rst", bus.out_valid, 0);
    rst = 1'b0;
    tick();
    bus.in_valid = 1'b0;
    check("post_rst_accept_busy", bus.busy, 1);
    wait_done(lat, busy_n);
    check("post_rst_latency", lat, 5);
    check("post_rst_p", bus.p, 8'h23);
    tick();

    // every operand pair back to back
    prev_cyc = 0;
    bus.in_valid = 1'b1;
    for (int i = 0; i < 256; i++) begin
      ai = i[7:4];
      bi = i[3:0];
      bus.a = ai;
      bus.b = bi;
      wait_ready("sweep");
      tick();
      acc_cyc = cyc;
      if (i == 255) bus.in_valid = 1'b0;
      if (i > 0) check("sweep_spacing", acc_cyc - prev_cyc, 7);
      prev_cyc = acc_cyc;
      wait_done(lat, busy_n);
      check("sweep_p", bus.p, int'(ai) * int'(bi));
    end
    tick();
    tick();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
